// File: rtl/spi_pkg.sv
// Register map, status/control bit positions and FSM states shared by the SPI slave port.
package spi_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

  localparam int ROE_BIT  = 3;
  localparam int TOE_BIT  = 4;
  localparam int TRDY_BIT = 6;
  localparam int RRDY_BIT = 7;
  localparam int E_BIT    = 8;
  localparam int EOP_BIT  = 9;

  // Bits of the control register that hold an irq enable.
  localparam logic [15:0] CTRL_MASK = 16'h03D8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// N-stage pin synchronizer with a selectable reset level.
module spi_slave_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {STAGES{RESET_VAL}};
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with pins oversampled in clk and a CPU register port.
// Define SPI_SLAVE_EOP_EN to build the eopvalue register and the EOP status/irq bit.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int          DATABITS      = 8,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] UNDERRUN_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [15:0] data_from_cpu,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int CNT_W = $clog2(DATABITS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATABITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATABITS - 1);

  logic sclk_s, ssn_s, mosi_s;
  logic sclk_d, ssn_d;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  spi_state_t state, state_nxt;
  logic load;

  logic [DATABITS-1:0] shift_tx, shift_rx, tx_hold, rx_hold, rx_word;
  logic [CNT_W-1:0]    bitcnt;
  logic                rx_done;

  logic rrdy, trdy, toe, roe, eop, e_flag;
  logic [15:0] ctrl_q, status_word, rd_data;
  logic acc, acc_d, acc_first, rd_first, wr_first;
  logic tx_wr, tx_accept, stat_wr;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .d(SS_n), .q(ssn_s)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(SCLK), .q(sclk_s)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(MOSI), .q(mosi_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d <= 1'b0;
      ssn_d  <= 1'b1;
      acc_d  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      ssn_d  <= ssn_s;
      acc_d  <= acc;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ssn_s & ssn_d;
  assign ss_rise   = ssn_s & ~ssn_d;

  // Register accesses last two cycles; side effects happen only in the first one.
  assign acc       = spi_select & (~read_n | ~write_n);
  assign acc_first = acc & ~acc_d;
  assign rd_first  = acc_first & ~read_n;
  assign wr_first  = acc_first & ~write_n;
  assign tx_wr     = wr_first & (mem_addr == ADDR_TXDATA);
  assign stat_wr   = wr_first & (mem_addr == ADDR_STATUS);
  // A write landing in the LOAD cycle is accepted because LOAD frees the holding register.
  assign tx_accept = tx_wr & (trdy | load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = (state == ST_LOAD);
    MISO_oe   = (state != ST_IDLE) & ~ssn_s;
    if (ss_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (ss_fall) state_nxt = ST_LOAD;
        ST_LOAD:  state_nxt = ST_SHIFT;
        ST_SHIFT: if (sclk_fall && bitcnt == FULL) state_nxt = ST_LOAD;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign MISO    = MISO_oe & shift_tx[DATABITS-1];
  assign rx_word = {shift_rx[DATABITS-2:0], mosi_s};
  assign rx_done = (state == ST_SHIFT) & ~ss_rise & sclk_rise & (bitcnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_tx <= '0;
      shift_rx <= '0;
      bitcnt   <= '0;
      rx_hold  <= '0;
      tx_hold  <= '0;
    end else begin
      if (load) begin
        shift_tx <= trdy ? UNDERRUN_WORD[DATABITS-1:0] : tx_hold;
        bitcnt   <= '0;
      end else if (state == ST_SHIFT && !ss_rise) begin
        if (sclk_rise && bitcnt != FULL) begin
          shift_rx <= rx_word;
          bitcnt   <= bitcnt + CNT_W'(1);
        end
        if (sclk_fall && bitcnt != '0 && bitcnt != FULL) shift_tx <= shift_tx << 1;
      end
      if (rx_done)   rx_hold <= rx_word;
      if (tx_accept) tx_hold <= data_from_cpu[DATABITS-1:0];
    end
  end

  // Status flags: clears first, so a same-cycle hardware set takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrdy   <= 1'b0;
      trdy   <= 1'b1;
      toe    <= 1'b0;
      roe    <= 1'b0;
      ctrl_q <= '0;
    end else begin
      if (stat_wr) begin
        rrdy <= 1'b0;
        toe  <= 1'b0;
        roe  <= 1'b0;
      end
      if (rd_first && mem_addr == ADDR_RXDATA) rrdy <= 1'b0;
      if (wr_first && mem_addr == ADDR_CONTROL) ctrl_q <= data_from_cpu & CTRL_MASK;
      if (load) trdy <= 1'b1;
      if (tx_accept)  trdy <= 1'b0;
      else if (tx_wr) toe  <= 1'b1;
      if (rx_done) begin
        rrdy <= 1'b1;
        if (rrdy) roe <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_EOP_EN
  logic [DATABITS-1:0] eop_val;
  logic                eop_hit;

  assign eop_hit = (rx_done && rx_word == eop_val) ||
                   (tx_wr && data_from_cpu[DATABITS-1:0] == eop_val);
  assign e_flag  = toe | roe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eop_val <= '0;
      eop     <= 1'b0;
    end else begin
      if (wr_first && mem_addr == ADDR_EOPVAL) eop_val <= data_from_cpu[DATABITS-1:0];
      if (eop_hit)      eop <= 1'b1;
      else if (stat_wr) eop <= 1'b0;
    end
  end
`else
  assign eop    = 1'b0;
  assign e_flag = 1'b0;
`endif

  always_comb begin
    status_word           = '0;
    status_word[EOP_BIT]  = eop;
    status_word[E_BIT]    = e_flag;
    status_word[RRDY_BIT] = rrdy;
    status_word[TRDY_BIT] = trdy;
    status_word[TOE_BIT]  = toe;
    status_word[ROE_BIT]  = roe;
  end

  always_comb begin
    rd_data = '0;
    case (mem_addr)
      ADDR_RXDATA:  rd_data = 16'(rx_hold);
      ADDR_STATUS:  rd_data = status_word;
      ADDR_CONTROL: rd_data = ctrl_q;
`ifdef SPI_SLAVE_EOP_EN
      ADDR_EOPVAL:  rd_data = 16'(eop_val);
`endif
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      if (rd_first) data_to_cpu <= rd_data;
      irq <= |(status_word & ctrl_q);
    end
  end

  assign dataavailable = rrdy;
  assign readyfordata  = trdy & ~toe;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: bit-banged SPI master at clk/8, CPU register tasks and a
// queue-based scoreboard for MISO and rxdata words. EOP checks build with SPI_SLAVE_EOP_EN.
`timescale 1ns/1ps
module tb_spi_slave_port;
  import spi_pkg::*;

  localparam logic [7:0] UNDERRUN = 8'h00;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, MISO_oe;
  logic [15:0] data_from_cpu = '0;
  logic [2:0]  mem_addr = '0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic        spi_select = 1'b0;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata;

  spi_slave_port dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .data_from_cpu(data_from_cpu),
    .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .spi_select(spi_select), .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit          m_rrdy, m_trdy, m_toe, m_roe, m_eop;
  logic [15:0] m_ctrl, m_eopval;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rrdy = 0; m_trdy = 1; m_toe = 0; m_roe = 0; m_eop = 0;
    m_ctrl = '0; m_eopval = '0;
    tx_q.delete();
    rx_q.delete();
  endtask

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s = '0;
    s[RRDY_BIT] = m_rrdy;
    s[TRDY_BIT] = m_trdy;
    s[TOE_BIT]  = m_toe;
    s[ROE_BIT]  = m_roe;
`ifdef SPI_SLAVE_EOP_EN
    s[EOP_BIT]  = m_eop;
    s[E_BIT]    = m_toe | m_roe;
`endif
    return s;
  endfunction

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
    case (a)
      ADDR_TXDATA: begin
        if (m_trdy) begin tx_q.push_back(d[7:0]); m_trdy = 0; end
        else m_toe = 1;
        if (d[7:0] == m_eopval[7:0]) m_eop = 1;
      end
      ADDR_STATUS:  begin m_rrdy = 0; m_toe = 0; m_roe = 0; m_eop = 0; end
      ADDR_CONTROL: m_ctrl = d & CTRL_MASK;
      ADDR_EOPVAL:  m_eopval = d & 16'h00FF;
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(negedge clk);
    d = data_to_cpu;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    if (a == ADDR_RXDATA) m_rrdy = 0;
    @(negedge clk);
  endtask

  task automatic check_pins(input string tag);
    chk({tag, "_irq"}, 16'(irq), 16'(|(exp_status() & m_ctrl)));
    chk({tag, "_davail"}, 16'(dataavailable), 16'(m_rrdy));
    chk({tag, "_rfd"}, 16'(readyfordata), 16'(m_trdy & ~m_toe));
  endtask

  task automatic check_status(input string tag);
    logic [15:0] d;
    cpu_read(ADDR_STATUS, d);
    chk(tag, d, exp_status());
  endtask

  task automatic check_rx(input string tag);
    logic [15:0] d;
    logic [7:0]  e;
    cpu_read(ADDR_RXDATA, d);
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    chk(tag, d, 16'(e));
  endtask

  task automatic spi_frame(input logic [7:0] w, input int nbits, input bit hold,
                           output logic [7:0] got);
    got = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[7-i];
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      got = {got[6:0], MISO};
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    if (!hold) begin
      repeat (6) @(negedge clk);
      SS_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  // Drives one frame and updates the scoreboard: MISO word popped at frame start,
  // received word pushed once the frame is complete.
  task automatic master_xfer(input string tag, input logic [7:0] w, input int nbits,
                             input bit hold);
    logic [7:0] got, exp_m;
    exp_m = (tx_q.size() > 0) ? tx_q.pop_front() : UNDERRUN;
    m_trdy = 1;
    spi_frame(w, nbits, hold, got);
    if (nbits == 8) begin
      chk({tag, "_miso"}, 16'(got), 16'(exp_m));
      if (m_rrdy) m_roe = 1;
      m_rrdy = 1;
      rx_q.delete();
      rx_q.push_back(w);
`ifdef SPI_SLAVE_EOP_EN
      if (w == m_eopval[7:0]) m_eop = 1;
`endif
      if (!hold) begin
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        m_trdy = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pins", 16'({MISO, MISO_oe, irq, dataavailable, readyfordata}), 16'h0001);
    chk("rst_dout", data_to_cpu, 16'h0000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_status("rst_status");

    // Pre-loaded tx word while receiving 0x3C
    cpu_write(ADDR_TXDATA, 16'h00A5);
    master_xfer("t1", 8'h3C, 8, 1'b0);
    chk("t1_oe_idle", 16'(MISO_oe), 16'h0000);
    check_pins("t1");
    check_status("t1_status");
    check_rx("t1_rx");

    // Overrun with ROE interrupt enabled
    cpu_write(ADDR_CONTROL, 16'h0008);
    master_xfer("t2a", 8'h11, 8, 1'b0);
    master_xfer("t2b", 8'h22, 8, 1'b0);
    check_pins("t2");
    check_status("t2_status");
    check_rx("t2_rx");
    cpu_write(ADDR_STATUS, 16'h0000);
    check_pins("t2_clr");
    cpu_write(ADDR_CONTROL, 16'h0000);

    // Underrun, then a dropped second tx write
    master_xfer("t3a", 8'h5A, 8, 1'b0);
    check_rx("t3_rx");
    cpu_write(ADDR_TXDATA, 16'h0077);
    cpu_write(ADDR_TXDATA, 16'h0099);
    check_pins("t3_toe");
    check_status("t3_status");
    master_xfer("t3b", 8'hC6, 8, 1'b0);
    check_rx("t3b_rx");
    cpu_write(ADDR_STATUS, 16'h0000);

    // Aborted frame after 4 bits
    master_xfer("t4a", 8'hF0, 4, 1'b0);
    chk("t4_fsm", 16'(dut.state), 16'(ST_IDLE));
    chk("t4_oe", 16'(MISO_oe), 16'h0000);
    check_pins("t4");
    check_status("t4_status");
    master_xfer("t4b", 8'h81, 8, 1'b0);
    check_rx("t4_rx");

`ifdef SPI_SLAVE_EOP_EN
    begin
      logic [15:0] d;
      cpu_write(ADDR_EOPVAL, 16'h000D);
      cpu_read(ADDR_EOPVAL, d);
      chk("t5_eopval", d, 16'h000D);
      cpu_write(ADDR_CONTROL, 16'h0200);
      fork
        master_xfer("t5", 8'h0D, 8, 1'b0);
        begin
          int n;
          n = 0;
          while (!dataavailable && n < 400) begin @(negedge clk); n++; end
          if (!dataavailable) chk("t5_wait", 16'h0000, 16'h0001);
          else begin
            chk("t5_irq_lag0", 16'(irq), 16'h0000);
            @(negedge clk);
            chk("t5_irq_lag1", 16'(irq), 16'h0001);
          end
        end
      join
      check_status("t5_status");
      check_rx("t5_rx");
      cpu_write(ADDR_STATUS, 16'h0000);
      check_pins("t5_clr");
      check_status("t5_clr_status");
      cpu_write(ADDR_TXDATA, 16'h000D);
      check_status("t5_tx_eop");
      master_xfer("t5b", 8'h44, 8, 1'b0);
      check_rx("t5b_rx");
      cpu_write(ADDR_STATUS, 16'h0000);
      cpu_write(ADDR_CONTROL, 16'h0000);
    end
`endif

    // Reset in the middle of a frame
    cpu_write(ADDR_CONTROL, 16'h0080);
    master_xfer("t6a", 8'hE7, 8, 1'b0);
    check_pins("t6_pre");
    check_status("t6_pre_status");
    cpu_write(ADDR_TXDATA, 16'h005A);
    master_xfer("t6b", 8'h96, 3, 1'b1);
    chk("t6_oe_active", 16'(MISO_oe), 16'h0001);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_pins", 16'({MISO, MISO_oe, irq, dataavailable, readyfordata}), 16'h0001);
    chk("t6_rst_dout", data_to_cpu, 16'h0000);
    chk("t6_rst_fsm", 16'(dut.state), 16'(ST_IDLE));
    SCLK = 1'b0;
    @(negedge clk);
    SS_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    check_status("t6_post_status");
    cpu_write(ADDR_TXDATA, 16'h00B4);
    master_xfer("t6c", 8'h3E, 8, 1'b0);
    check_rx("t6_rx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
